mult_share_arbiter: RTL and testbench

- Shares one 4x4 `Array_multiplier` instance (combinational, 8-bit product) between four requesters.
- Round-robin arbitration, operand capture, a configurable settle wait, and result return with a valid/ready handshake.
- Sits between client blocks and the single multiplier, so the multiplier array is not duplicated per client.

---
 rtl/mult_share_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Purpose:
//   Shares a single combinational 4x4 array multiplier between four client
//   requesters. A round-robin arbiter picks one requester and captures its
//   operands. The captured operands settle through the multiplier for LATENCY
//   cycles, and the registered product is then returned to the owner with a
//   valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     per-requester request, bit i belongs to requester i
//   req_a[15:0]  packed multiplicands, [4i+3:4i] belongs to requester i
//   req_b[15:0]  packed multipliers,   [4i+3:4i] belongs to requester i
//   gnt[3:0]     one-hot grant; the winner's operands are captured this edge
//   busy         high whenever the block is not idle
//   rsp_valid    result available
//   rsp_id[1:0]  requester that owns the result
//   rsp_product  registered unsigned product
//   rsp_ready    consumer accepts the result
//
// Parameters:
//   NUM_REQ  number of requesters (fixed at 4, the ID field is 2 bits)
//   LATENCY  cycles spent in COMPUTE before the product is registered (1..15)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// Array_multiplier
//
// Purpose:
//   Unsigned 4x4 combinational array multiplier built from AND-gate partial
//   products and rows of ripple-carry full adders.
//
// Ports:
//   inp1[3:0]     multiplicand
//   inp2[3:0]     multiplier
//   product[7:0]  inp1 * inp2
// -----------------------------------------------------------------------------
module Array_multiplier (
  input  logic [3:0] inp1,
  input  logic [3:0] inp2,
  output logic [7:0] product
);

  logic [3:0] pp [4];
  logic [4:0] row;
  logic [4:0] row_nxt;
  logic       carry;
  logic       fa_a;
  logic       fa_b;

  // Each adder row adds the next partial product to the upper four bits of the
  // previous row; the bit shifted out at the bottom is one final product bit.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      pp[r] = inp1 & {4{inp2[r]}};
    end

    product    = '0;
    row        = {1'b0, pp[0]};
    row_nxt    = '0;
    carry      = 1'b0;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    product[0] = row[0];

    for (int r = 1; r < 4; r++) begin
      carry = 1'b0;
      for (int j = 0; j < 4; j++) begin
        fa_a       = row[j+1];
        fa_b       = pp[r][j];
        row_nxt[j] = fa_a ^ fa_b ^ carry;
        carry      = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);
      end
      row_nxt[4] = carry;
      row        = row_nxt;
      product[r] = row[0];
    end

    product[7:4] = row[4:1];
  end

endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output logic [7:0]             rsp_product,
  input  logic                   rsp_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [1:0] cur_id;

  logic [1:0] winner;
  logic       found;
  logic [1:0] idx;
  logic       grant_any;
  logic [7:0] mult_product;

  // Round-robin search: scan from the pointer upward with wrap and keep the
  // first requester found. The 2-bit index wraps naturally modulo 4.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Grants are only offered while idle and never during reset, so a
  // request arriving while busy simply waits for the next idle cycle.
  always_comb begin
    gnt = '0;
    if (state == IDLE && !rst && found) begin
      gnt[winner] = 1'b1;
    end
    grant_any = |gnt;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  // Datapath: operand capture, pointer update, settle counter and result
  // registers. rsp_product/rsp_id only change when leaving COMPUTE, so they
  // stay stable throughout RESP regardless of rsp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      cur_id      <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a   <= req_a[{winner, 2'b00} +: 4];
            op_b   <= req_b[{winner, 2'b00} +: 4];
            cur_id <= winner;
            ptr    <= winner + 2'd1;
            cnt    <= 4'(LATENCY);
          end
        end
        COMPUTE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_product <= mult_product;
            rsp_id      <= cur_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  Array_multiplier u_mult (
    .inp1    (op_a),
    .inp2    (op_b),
    .product (mult_product)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Purpose:
//   Directed self-checking bench for mult_share_arbiter. Three instances with
//   LATENCY 1, 3 and 4 share one set of inputs; each scenario starts from a
//   reset and observes the instance whose latency it needs.
//   Index 0 = LATENCY 1, index 1 = LATENCY 3, index 2 = LATENCY 4.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_ready;

  logic [3:0]  gnt_w     [3];
  logic        busy_w    [3];
  logic        valid_w   [3];
  logic [1:0]  id_w      [3];
  logic [7:0]  prod_w    [3];

  int checks;
  int passes;

  mult_share_arbiter #(.NUM_REQ(4), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt_w[0]), .busy(busy_w[0]), .rsp_valid(valid_w[0]),
    .rsp_id(id_w[0]), .rsp_product(prod_w[0]), .rsp_ready(rsp_ready)
  );

  mult_share_arbiter #(.NUM_REQ(4), .LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt_w[1]), .busy(busy_w[1]), .rsp_valid(valid_w[1]),
    .rsp_id(id_w[1]), .rsp_product(prod_w[1]), .rsp_ready(rsp_ready)
  );

  mult_share_arbiter #(.NUM_REQ(4), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt_w[2]), .busy(busy_w[2]), .rsp_valid(valid_w[2]),
    .rsp_id(id_w[2]), .rsp_product(prod_w[2]), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // Bounded wait for any grant on instance d; returns with gnt possibly 0.
  task automatic wait_gnt(input int d, input int max_cyc);
    int n;
    n = 0;
    while (gnt_w[d] == 4'b0000 && n < max_cyc) begin
      tick();
      settle();
      n++;
    end
  endtask

  // Bounded wait for rsp_valid on instance d; n is cycles waited.
  task automatic wait_valid(input int d, input int max_cyc, output int n);
    n = 0;
    while (valid_w[d] !== 1'b1 && n < max_cyc) begin
      tick();
      settle();
      n++;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst   = 1'b1;
    req   = 4'b1111;
    tick();
    settle();
    checks++;
    if (gnt_w[0] !== 4'b0000) $display("[TB] FAIL reset_gnt_blocked: got %b want 0000", gnt_w[0]);
    else passes++;
    do_reset();
    checks++;
    if ({gnt_w[0], busy_w[0], valid_w[0], id_w[0], prod_w[0]} !== 16'h0000)
      $display("[TB] FAIL reset_outputs: gnt=%b busy=%b valid=%b id=%0d prod=%0d want all 0",
               gnt_w[0], busy_w[0], valid_w[0], id_w[0], prod_w[0]);
    else passes++;
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    do_reset();
    req   = 4'b0001;
    req_a = 16'h0003;
    req_b = 16'h0004;
    settle();
    checks++;
    if (gnt_w[0] !== 4'b0001) $display("[TB] FAIL basic_gnt_c0: got %b want 0001", gnt_w[0]);
    else passes++;
    tick();
    req = 4'b0000;
    settle();
    checks++;
    if (busy_w[0] !== 1'b1 || valid_w[0] !== 1'b0)
      $display("[TB] FAIL basic_c1: busy=%b valid=%b want busy=1 valid=0", busy_w[0], valid_w[0]);
    else passes++;
    tick();
    settle();
    checks++;
    if (valid_w[0] !== 1'b1 || id_w[0] !== 2'd0 || prod_w[0] !== 8'd12)
      $display("[TB] FAIL basic_rsp_c2: valid=%b id=%0d prod=%0d want 1/0/12", valid_w[0], id_w[0], prod_w[0]);
    else passes++;
    tick();
    settle();
    checks++;
    if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0)
      $display("[TB] FAIL basic_c3_idle: busy=%b valid=%b want 0/0", busy_w[0], valid_w[0]);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_prod [4];
    int n;
    int w;
    $display("[TB] test_round_robin");
    exp_prod[0] = 8'd195;
    exp_prod[1] = 8'd120;
    exp_prod[2] = 8'd66;
    exp_prod[3] = 8'd225;
    do_reset();
    req   = 4'b1111;
    req_a = {4'd15, 4'd11, 4'd10, 4'd13};
    req_b = {4'd15, 4'd6,  4'd12, 4'd15};
    settle();
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      wait_gnt(0, 10);
      checks++;
      if (gnt_w[0] !== 4'(1 << w)) $display("[TB] FAIL rr_gnt_%0d: got %b want %b", k, gnt_w[0], 4'(1 << w));
      else passes++;
      tick();
      settle();
      wait_valid(0, 10, n);
      checks++;
      if (valid_w[0] !== 1'b1 || id_w[0] !== 2'(w) || prod_w[0] !== exp_prod[w])
        $display("[TB] FAIL rr_rsp_%0d: valid=%b id=%0d prod=%0d want 1/%0d/%0d",
                 k, valid_w[0], id_w[0], prod_w[0], w, exp_prod[w]);
      else passes++;
      tick();
      settle();
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int n;
    $display("[TB] test_back_to_back_backpressure");
    do_reset();
    rsp_ready = 1'b0;
    req       = 4'b0100;
    req_a     = 16'h0500;
    req_b     = 16'h0600;
    settle();
    wait_gnt(0, 5);
    tick();
    settle();
    wait_valid(0, 10, n);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (valid_w[0] !== 1'b1 || prod_w[0] !== 8'd30 || id_w[0] !== 2'd2 ||
          gnt_w[0] !== 4'b0000 || busy_w[0] !== 1'b1)
        $display("[TB] FAIL bp_hold_%0d: valid=%b prod=%0d id=%0d gnt=%b busy=%b want 1/30/2/0000/1",
                 c, valid_w[0], prod_w[0], id_w[0], gnt_w[0], busy_w[0]);
      else passes++;
      tick();
      settle();
    end
    rsp_ready = 1'b1;
    settle();
    tick();
    settle();
    checks++;
    if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || gnt_w[0] !== 4'b0100)
      $display("[TB] FAIL bp_release: busy=%b valid=%b gnt=%b want 0/0/0100", busy_w[0], valid_w[0], gnt_w[0]);
    else passes++;
  endtask

  task automatic test_pointer_wrap();
    int n;
    $display("[TB] test_pointer_wrap");
    do_reset();
    req   = 4'b1000;
    req_a = 16'h2001;
    req_b = 16'h3001;
    settle();
    checks++;
    if (gnt_w[0] !== 4'b1000) $display("[TB] FAIL wrap_gnt_3: got %b want 1000", gnt_w[0]);
    else passes++;
    tick();
    req = 4'b1001;
    settle();
    wait_valid(0, 10, n);
    tick();
    settle();
    wait_gnt(0, 5);
    checks++;
    if (gnt_w[0] !== 4'b0001) $display("[TB] FAIL wrap_gnt_0: got %b want 0001", gnt_w[0]);
    else passes++;
    tick();
    settle();
    wait_valid(0, 10, n);
    tick();
    settle();
    wait_gnt(0, 5);
    checks++;
    if (gnt_w[0] !== 4'b1000) $display("[TB] FAIL wrap_gnt_3_again: got %b want 1000", gnt_w[0]);
    else passes++;
  endtask

  task automatic test_mid_reset();
    bit saw_valid;
    $display("[TB] test_mid_reset");
    do_reset();
    req   = 4'b0100;
    req_a = 16'h0700;
    req_b = 16'h0800;
    settle();
    checks++;
    if (gnt_w[2] !== 4'b0100) $display("[TB] FAIL mid_gnt: got %b want 0100", gnt_w[2]);
    else passes++;
    tick();
    req = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if ({gnt_w[2], busy_w[2], valid_w[2], id_w[2], prod_w[2]} !== 16'h0000)
      $display("[TB] FAIL mid_outputs: gnt=%b busy=%b valid=%b id=%0d prod=%0d want all 0",
               gnt_w[2], busy_w[2], valid_w[2], id_w[2], prod_w[2]);
    else passes++;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (valid_w[2] !== 1'b0) saw_valid = 1'b1;
      tick();
      settle();
    end
    checks++;
    if (saw_valid) $display("[TB] FAIL mid_no_rsp: saw rsp_valid=1 want none");
    else passes++;
    req = 4'b1010;
    settle();
    checks++;
    if (gnt_w[2] !== 4'b0010) $display("[TB] FAIL mid_ptr_reset: got %b want 0010", gnt_w[2]);
    else passes++;
  endtask

  task automatic test_latency();
    int n;
    $display("[TB] test_latency");
    do_reset();
    req   = 4'b0001;
    req_a = 16'h0009;
    req_b = 16'h0007;
    settle();
    checks++;
    if (gnt_w[1] !== 4'b0001) $display("[TB] FAIL lat_gnt: got %b want 0001", gnt_w[1]);
    else passes++;
    tick();
    req = 4'b0000;
    settle();
    wait_valid(1, 20, n);
    checks++;
    if (n + 1 !== 4) $display("[TB] FAIL lat_cycles: valid after %0d cycles want 4", n + 1);
    else passes++;
    checks++;
    if (valid_w[1] !== 1'b1 || prod_w[1] !== 8'd63)
      $display("[TB] FAIL lat_prod: valid=%b prod=%0d want 1/63", valid_w[1], prod_w[1]);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back_backpressure();
    test_pointer_wrap();
    test_mid_reset();
    test_latency();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
